// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus: instruction/operands in, redirect/flush/link out.
interface branch_resolve_if;
  logic        i_valid;
  logic        i_is_branch;
  logic        i_is_jal;
  logic        i_is_jalr;
  logic [2:0]  i_funct3;
  logic [31:0] i_pc;
  logic [31:0] i_imm;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_stall;
  logic        o_b_taken;
  logic [31:0] o_b_pc;
  logic        o_flush;
  logic [31:0] o_link;
  logic        o_link_valid;
  logic        o_misalign;
  logic        o_busy;

  modport master (
    output i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_imm, i_rs1, i_rs2, i_stall,
    input  o_b_taken, o_b_pc, o_flush, o_link, o_link_valid, o_misalign, o_busy
  );

  modport slave (
    input  i_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
           i_pc, i_imm, i_rs1, i_rs2, i_stall,
    output o_b_taken, o_b_pc, o_flush, o_link, o_link_valid, o_misalign, o_busy
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves branches/JAL/JALR, issues a stall-tolerant redirect to fetch and
// flushes the younger IF/ID instructions for FLUSH_CYCLES cycles.
module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  branch_resolve_if.slave   bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              b_taken_q;
  logic [XLEN-1:0]   b_pc_q;
  logic              flush_q;
  logic [XLEN-1:0]   link_q;
  logic              link_valid_q;
  logic              misalign_q;

  logic              cond_c;
  logic              taken_c;
  logic              jump_c;
  logic [XLEN-1:0]   target_c;

  // Branch condition, taken decision and target address.
  always_comb begin
    cond_c = 1'b0;
    case (bus.i_funct3)
      3'b000:  cond_c = (bus.i_rs1 == bus.i_rs2);
      3'b001:  cond_c = (bus.i_rs1 != bus.i_rs2);
      3'b100:  cond_c = ($signed(bus.i_rs1) <  $signed(bus.i_rs2));
      3'b101:  cond_c = ($signed(bus.i_rs1) >= $signed(bus.i_rs2));
      3'b110:  cond_c = (bus.i_rs1 <  bus.i_rs2);
      3'b111:  cond_c = (bus.i_rs1 >= bus.i_rs2);
      default: cond_c = 1'b0;
    endcase
    jump_c   = bus.i_is_jal | bus.i_is_jalr;
    taken_c  = jump_c | (bus.i_is_branch & cond_c);
    target_c = bus.i_is_jalr ? ((bus.i_rs1 + bus.i_imm) & ~XLEN'(1))
                             : (bus.i_pc + bus.i_imm);
  end

  // Redirect FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      b_taken_q    <= 1'b0;
      b_pc_q       <= '0;
      flush_q      <= 1'b0;
      link_q       <= '0;
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            if (jump_c) begin
              link_q       <= bus.i_pc + XLEN'(4);
              link_valid_q <= 1'b1;
            end
            if (taken_c) begin
              b_pc_q <= target_c;
              if (target_c[1:0] != 2'b00) begin
                misalign_q <= 1'b1;
              end else begin
                state     <= REDIRECT;
                b_taken_q <= 1'b1;
                flush_q   <= 1'b1;
              end
            end
          end
        end
        REDIRECT: begin
          // Hold target and request until fetch takes it.
          if (!bus.i_stall) begin
            b_taken_q <= 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state   <= IDLE;
              flush_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (cnt <= CNT_W'(1)) begin
            state   <= IDLE;
            flush_q <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          b_taken_q <= 1'b0;
          flush_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_b_taken    = b_taken_q;
  assign bus.o_b_pc       = b_pc_q;
  assign bus.o_flush      = flush_q;
  assign bus.o_link       = link_q;
  assign bus.o_link_valid = link_valid_q;
  assign bus.o_misalign   = misalign_q;
  assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed test-plan steps followed by
// random instructions, all compared against a cycle-timestamp reference model.
module tb_branch_resolve;
  localparam int FC = 2;

  logic clk;
  logic rst;
  branch_resolve_if bus ();

  branch_resolve #(.FLUSH_CYCLES(FC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: outstanding redirect, last flushed cycle, held values.
  int          cyc = 0;
  bit          m_pend = 0;
  int          m_flush_end = -1;
  logic [31:0] m_bpc = '0;
  logic [31:0] m_link = '0;
  bit          m_lv = 0;
  bit          m_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all();
    bit fl;
    fl = m_pend || (cyc <= m_flush_end);
    chk("b_taken",    32'(bus.o_b_taken),    32'(m_pend));
    chk("b_pc",       bus.o_b_pc,            m_bpc);
    chk("flush",      32'(bus.o_flush),      32'(fl));
    chk("busy",       32'(bus.o_busy),       32'(fl));
    chk("link",       bus.o_link,            m_link);
    chk("link_valid", 32'(bus.o_link_valid), 32'(m_lv));
    chk("misalign",   32'(bus.o_misalign),   32'(m_mis));
  endtask

  task automatic model_reset();
    m_pend = 0; m_flush_end = -1; m_bpc = '0; m_link = '0; m_lv = 0; m_mis = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check the outputs after the edge.
  task automatic step(input logic v, input logic br, input logic jal, input logic jalr,
                      input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] b, input logic st);
    bit          idle;
    bit          tk;
    logic [31:0] tgt;
    bus.i_valid = v; bus.i_is_branch = br; bus.i_is_jal = jal; bus.i_is_jalr = jalr;
    bus.i_funct3 = f3; bus.i_pc = pc; bus.i_imm = imm; bus.i_rs1 = a; bus.i_rs2 = b;
    bus.i_stall = st;
    idle = !m_pend && (cyc > m_flush_end);
    m_lv = 0; m_mis = 0;
    if (m_pend && !st) begin
      m_pend = 0;
      m_flush_end = cyc + FC - 1;
    end else if (idle && v && (br || jal || jalr)) begin
      tk  = jal || jalr || (br && ref_cond(f3, a, b));
      tgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      if (jal || jalr) begin m_link = pc + 32'd4; m_lv = 1; end
      if (tk) begin
        m_bpc = tgt;
        if (tgt[1:0] != 2'b00) m_mis = 1;
        else m_pend = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic nop(input logic st);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, st);
  endtask

  task automatic zeros_check();
    chk("rst_b_taken",    32'(bus.o_b_taken),    32'h0);
    chk("rst_b_pc",       bus.o_b_pc,            32'h0);
    chk("rst_flush",      32'(bus.o_flush),      32'h0);
    chk("rst_link",       bus.o_link,            32'h0);
    chk("rst_link_valid", 32'(bus.o_link_valid), 32'h0);
    chk("rst_misalign",   32'(bus.o_misalign),   32'h0);
    chk("rst_busy",       32'(bus.o_busy),       32'h0);
  endtask

  initial begin
    logic        r_br, r_jal, r_jalr, r_v, r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_pc, r_imm, r_a, r_b;
    int          kind;

    rst = 1'b1;
    bus.i_valid = 0; bus.i_is_branch = 0; bus.i_is_jal = 0; bus.i_is_jalr = 0;
    bus.i_funct3 = 0; bus.i_pc = 0; bus.i_imm = 0; bus.i_rs1 = 0; bus.i_rs2 = 0;
    bus.i_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    zeros_check();
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, no stall
    step(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0);
    chk("beq_target", bus.o_b_pc, 32'h120);
    nop(0); nop(0); nop(0);

    // BLT taken (signed), BLTU not taken (unsigned)
    step(1, 1, 0, 0, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    nop(0); nop(0);
    step(1, 1, 0, 0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    chk("bltu_not_taken", 32'(bus.o_b_taken), 32'h0);
    nop(0); nop(0);

    // JALR misaligned target, then aligned JALR
    step(1, 0, 0, 1, 3'b000, 32'h40, 32'h0, 32'h1003, 32'h0, 0);
    chk("jalr_mis_pc",   bus.o_b_pc, 32'h1002);
    chk("jalr_mis_link", bus.o_link, 32'h44);
    nop(0);
    step(1, 0, 0, 1, 3'b000, 32'h40, 32'h0, 32'h1001, 32'h0, 0);
    chk("jalr_pc", bus.o_b_pc, 32'h1000);
    nop(0); nop(0);

    // JAL with 3 stalled cycles and wrong-path valids during the window
    step(1, 0, 1, 0, 3'b000, 32'h80, 32'h10, 32'h0, 32'h0, 0);
    step(1, 1, 0, 0, 3'b000, 32'h500, 32'h8, 32'd1, 32'd1, 1);
    step(1, 0, 1, 0, 3'b000, 32'h600, 32'h8, 32'd0, 32'd0, 1);
    step(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'd0, 32'd0, 1);
    chk("jal_stall_pc", bus.o_b_pc, 32'h90);
    step(1, 1, 0, 0, 3'b001, 32'h700, 32'h8, 32'd1, 32'd2, 0);
    step(1, 0, 0, 1, 3'b000, 32'h700, 32'h8, 32'd0, 32'd0, 0);
    nop(0);

    // Target wraparound
    step(1, 1, 0, 0, 3'b001, 32'hFFFF_FFFC, 32'd8, 32'd1, 32'd2, 0);
    chk("wrap_pc", bus.o_b_pc, 32'h0000_0004);
    nop(0);

    // Asynchronous reset while in FLUSH
    #2 rst = 1'b1;
    #1 zeros_check();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    nop(0);
    step(1, 1, 0, 0, 3'b101, 32'h400, 32'h10, 32'd7, 32'd3, 0);
    chk("post_rst_pc", bus.o_b_pc, 32'h410);
    nop(0); nop(0);

    // Random instruction mix
    for (int i = 0; i < 400; i++) begin
      r_v   = ($urandom_range(0, 9) < 7);
      kind  = $urandom_range(0, 9);
      r_br  = (kind < 6);
      r_jal = (kind == 6 || kind == 7);
      r_jalr = (kind == 8);
      r_f3  = 3'($urandom);
      r_pc  = $urandom & 32'hFFFF_FFFC;
      r_imm = 32'($urandom_range(0, 511)) - 32'd256;
      if ($urandom_range(0, 3) != 0) r_imm = r_imm & 32'hFFFF_FFFC;
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
      if ($urandom_range(0, 3) == 0) r_b = ~r_a;
      r_st  = ($urandom_range(0, 9) < 4);
      step(r_v, r_br, r_jal, r_jalr, r_f3, r_pc, r_imm, r_a, r_b, r_st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

- Resolves conditional branches and JAL/JALR in the execute stage.
- Drives the redirect inputs of the fetch stage: `o_b_taken` feeds `i_b_taken` and `o_b_pc` feeds `i_b_pc`.
- On a taken redirect it flushes the younger IF/ID instructions for a fixed number of cycles and supplies the link value for jumps.
- It holds a pending redirect while fetch is stalled, so no redirect is ever lost.

## Interface
Parameters:
- FLUSH_CYCLES, 2, total cycles `o_flush` is asserted per redirect (≥1), including the redirect cycle

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  execute-stage instruction valid
- i_is_branch  input  1  conditional branch (funct3 selects the condition)
- i_is_jal  input  1  JAL
- i_is_jalr  input  1  JALR
- i_funct3  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 never taken
- i_pc  input  32  PC of the execute instruction
- i_imm  input  32  sign-extended immediate
- i_rs1  input  32  rs1 operand
- i_rs2  input  32  rs2 operand
- i_stall  input  1  fetch cannot accept a redirect this cycle
- o_b_taken  output  1  redirect request to fetch
- o_b_pc  output  32  redirect target
- o_flush  output  1  squash IF/ID contents
- o_link  output  32  pc+4 for JAL/JALR
- o_link_valid  output  1  `o_link` valid (one-cycle pulse)
- o_misalign  output  1  target misaligned (one-cycle pulse)
- o_busy  output  1  FSM not IDLE

## Operation
Resolution is combinational and evaluated in a cycle where `i_valid`=1 and state=IDLE.
- Exactly one of `i_is_branch`, `i_is_jal`, `i_is_jalr` is high when `i_valid`=1. With none high, the instruction produces no action.
- Taken condition:
  - branch: `i_funct3` compare; signed for BLT/BGE, unsigned for BLTU/BGEU.
  - JAL and JALR: always taken.
- Target (32-bit wraparound; carry discarded, e.g. 0xFFFFFFFC+8 = 0x00000004):
  - branch and JAL: `i_pc` + `i_imm`.
  - JALR: (`i_rs1` + `i_imm`) & ~1.
- Misaligned when taken and target[1:0]≠0. In that case there is no redirect and no flush; `o_misalign` pulses for one cycle and the state stays IDLE.
- `o_link` = `i_pc`+4, registered; `o_link_valid` pulses for JAL/JALR regardless of misalignment.

FSM states:
- IDLE: evaluate. A taken, aligned result latches the target and goes to REDIRECT; otherwise stay.
- REDIRECT:
  - `o_b_taken`=1, `o_flush`=1.
  - If `i_stall`=1, stay and hold `o_b_pc` stable.
  - If `i_stall`=0, this is the acceptance cycle. Go to FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH: `o_flush`=1, `o_b_taken`=0. A counter starts at FLUSH_CYCLES-1 on entry and decrements every cycle. `i_stall` is ignored here. Go to IDLE when the counter hits 0.

While not IDLE, `i_valid` is ignored: those instructions are wrong-path and are being flushed.

## Timing
- Reset (asynchronous, any state, including mid-REDIRECT/FLUSH): state IDLE; every output is 0 (`o_b_taken`, `o_b_pc`, `o_flush`, `o_link`, `o_link_valid`, `o_misalign`, `o_busy`); counter cleared.
- Redirect latency: instruction valid in cycle N means `o_b_taken`/`o_b_pc`/`o_flush` are asserted from N+1.
- Stall: `o_b_taken` stays high through every stalled cycle, plus the first cycle with `i_stall`=0.
- `o_flush` duration: the stall cycles plus FLUSH_CYCLES in total. The last flush cycle is N+FLUSH_CYCLES+stalls.
- Back-to-back: the next instruction can be evaluated in the cycle the FSM is IDLE again, i.e. the cycle after the last `o_flush`.
- `o_link_valid` and `o_misalign` appear at N+1 and last one cycle.
- `o_busy` = state≠IDLE.
- `o_b_pc` holds its last value when `o_b_taken`=0; it resets to 0.

## Test plan
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, no stall -> N+1: `o_b_taken`=1, `o_b_pc`=0x120; `o_flush` high N+1..N+2; IDLE at N+3.
- BLT rs1=0xFFFFFFFF, rs2=1 (taken) and BLTU with the same operands (not taken) -> first redirects, second gives `o_b_taken`=0 and `o_flush`=0 throughout.
- JALR rs1=0x1003, imm=0, pc=0x40 -> `o_b_pc`=0x1002 with `o_misalign`=1 and no redirect, `o_link`=0x44, `o_link_valid` pulse. JALR rs1=0x1001 -> `o_b_pc`=0x1000 and redirect.
- JAL pc=0x80, imm=0x10 with `i_stall`=1 for 3 cycles -> `o_b_taken`=1, `o_b_pc`=0x90 held N+1..N+4; `o_flush` high N+1..N+5; `i_valid` pulses during this window cause no action.
- Wraparound: BNE pc=0xFFFFFFFC, imm=8 -> `o_b_pc`=0x00000004.
- Assert `i_rst` asynchronously mid-FLUSH -> all outputs 0 immediately; the next valid taken branch after release redirects normally.
